// File: rtl/pipe_hazard_unit.sv
// EX/MEM instruction tracking, load-use stall, branch squash and N/V/Z flag register.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipe_hazard_unit #(
    parameter int              ISIZE = 16,
    parameter int              RSIZE = 4,
    parameter logic [ISIZE-1:0] NOP  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ISIZE-1:0] InstrIn,
    input  logic             InstrValid,
    input  logic             FlushReq,
    input  logic [2:0]       ALUFlag,
    output logic [ISIZE-1:0] LastInstr,
    output logic [ISIZE-1:0] Last2Instr,
    output logic             LastValid,
    output logic             Last2Valid,
    output logic [2:0]       Flag,
`ifdef HAZARD_PERF_EN
    output logic [15:0]      StallCnt,
    output logic [15:0]      FlushCnt,
`endif
    output logic             Stall
);

    localparam int OP_W = ISIZE - 3 * RSIZE;

    localparam logic [OP_W-1:0] OP_LW   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_EXEC = OP_W'(15);

    logic [ISIZE-1:0] last_q, last_d;
    logic [ISIZE-1:0] last2_q, last2_d;
    logic             last_valid_q, last_valid_d;
    logic             last2_valid_q, last2_valid_d;
    logic [2:0]       flag_q, flag_d;

    logic [OP_W-1:0]  in_op, ex_op;
    logic [RSIZE-1:0] in_rd, in_rs, in_rt, ex_rd;
    logic             lw_in_ex, src_match, stall;

    assign in_op = InstrIn[ISIZE-1 -: OP_W];
    assign in_rd = InstrIn[3*RSIZE-1 -: RSIZE];
    assign in_rs = InstrIn[2*RSIZE-1 -: RSIZE];
    assign in_rt = InstrIn[RSIZE-1:0];
    assign ex_op = last_q[ISIZE-1 -: OP_W];
    assign ex_rd = last_q[3*RSIZE-1 -: RSIZE];

    // A load writing R0 produces nothing to wait for, so it is excluded here.
    always_comb begin
        lw_in_ex  = last_valid_q && (ex_op == OP_LW) && (ex_rd != '0);
        src_match = ((in_op < OP_W'(10)) && (in_rs == ex_rd))
                 || ((in_op < OP_W'(5))  && (in_rt == ex_rd))
                 || (((in_op == OP_JR) || (in_op == OP_EXEC)) && (in_rd == ex_rd));
        stall     = lw_in_ex && InstrValid && src_match;
    end

    always_comb begin
        last_d        = InstrIn;
        last_valid_d  = 1'b1;
        if (FlushReq || stall || !InstrValid) begin
            last_d       = NOP;
            last_valid_d = 1'b0;
        end
        last2_d       = last_q;
        last2_valid_d = last_valid_q;

        flag_d = flag_q;
        if (last_valid_q) begin
            if (ex_op <= OP_W'(1)) begin
                flag_d = ALUFlag;
            end else if (ex_op <= OP_W'(7)) begin
                flag_d[0] = ALUFlag[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q        <= NOP;
            last2_q       <= NOP;
            last_valid_q  <= 1'b0;
            last2_valid_q <= 1'b0;
            flag_q        <= 3'b000;
        end else begin
            last_q        <= last_d;
            last2_q       <= last2_d;
            last_valid_q  <= last_valid_d;
            last2_valid_q <= last2_valid_d;
            flag_q        <= flag_d;
        end
    end

    assign LastInstr  = last_q;
    assign Last2Instr = last2_q;
    assign LastValid  = last_valid_q;
    assign Last2Valid = last2_valid_q;
    assign Flag       = flag_q;
    assign Stall      = stall;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (FlushReq && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed test-plan sequences followed by randomized traffic, all checked against a
// behavioural model of the decode/EX/MEM pipeline kept in this bench.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] InstrIn;
    logic        InstrValid;
    logic        FlushReq;
    logic [2:0]  ALUFlag;
    logic [15:0] LastInstr, Last2Instr;
    logic        LastValid, Last2Valid;
    logic [2:0]  Flag;
    logic        Stall;
`ifdef HAZARD_PERF_EN
    logic [15:0] StallCnt, FlushCnt;
`endif

    pipe_hazard_unit dut (
        .clk       (clk),
        .rst       (rst),
        .InstrIn   (InstrIn),
        .InstrValid(InstrValid),
        .FlushReq  (FlushReq),
        .ALUFlag   (ALUFlag),
        .LastInstr (LastInstr),
        .Last2Instr(Last2Instr),
        .LastValid (LastValid),
        .Last2Valid(Last2Valid),
        .Flag      (Flag),
`ifdef HAZARD_PERF_EN
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt),
`endif
        .Stall     (Stall)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Model state: the instruction sitting in EX and MEM, flags and event counts.
    logic [15:0] m_ex, m_mem;
    logic        m_ex_v, m_mem_v;
    logic [2:0]  m_flag;
    int          m_stalls, m_flushes;
    logic        obs_stall;

    function automatic bit reads_reg(input logic [15:0] i, input logic [3:0] r);
        int op;
        op = int'(i[15:12]);
        return (op < 10 && i[7:4] == r) || (op < 5 && i[3:0] == r)
            || (op >= 14 && i[11:8] == r);
    endfunction

    function automatic bit model_stall(input logic [15:0] i, input logic v);
        return m_ex_v && m_ex[15:12] == 4'd8 && m_ex[11:8] != 4'd0 && v
            && reads_reg(i, m_ex[11:8]);
    endfunction

    task automatic step(input logic r, input logic [15:0] i, input logic v,
                        input logic f, input logic [2:0] af);
        bit exp_stall;
        int op;
        @(negedge clk);
        rst = r; InstrIn = i; InstrValid = v; FlushReq = f; ALUFlag = af;
        #1;
        exp_stall = model_stall(i, v);
        obs_stall = Stall;
        check("stall", Stall, exp_stall);
        if (r) begin
            m_ex = 16'h0000; m_mem = 16'h0000; m_ex_v = 0; m_mem_v = 0;
            m_flag = 3'b000; m_stalls = 0; m_flushes = 0;
        end else begin
            op = int'(m_ex[15:12]);
            if (m_ex_v && op <= 1) m_flag = af;
            else if (m_ex_v && op <= 7) m_flag[0] = af[0];
            if (exp_stall && m_stalls < 65535) m_stalls++;
            if (f && m_flushes < 65535) m_flushes++;
            m_mem = m_ex; m_mem_v = m_ex_v;
            if (f || exp_stall || !v) begin
                m_ex = 16'h0000; m_ex_v = 0;
            end else begin
                m_ex = i; m_ex_v = 1;
            end
        end
        @(posedge clk);
        #1;
        check("last_instr", LastInstr, m_ex);
        check("last2_instr", Last2Instr, m_mem);
        check("last_valid", LastValid, m_ex_v);
        check("last2_valid", Last2Valid, m_mem_v);
        check("flag", Flag, m_flag);
`ifdef HAZARD_PERF_EN
        check("stall_cnt", StallCnt, m_stalls);
        check("flush_cnt", FlushCnt, m_flushes);
`endif
        $display("txn rst=%0d in=%h v=%0d fl=%0d af=%b | stall=%0d ex=%h/%0d mem=%h/%0d flag=%b",
                 r, i, v, f, af, obs_stall, LastInstr, LastValid, Last2Instr, Last2Valid, Flag);
    endtask

    initial begin
        logic [15:0] ri;
        logic        rv, rf, rr;
        int          op;

        rst = 1; InstrIn = 16'h0; InstrValid = 0; FlushReq = 0; ALUFlag = 3'b0;
        m_ex = 0; m_mem = 0; m_ex_v = 0; m_mem_v = 0; m_flag = 0;
        m_stalls = 0; m_flushes = 0; obs_stall = 0;

        // Reset overrides a valid instruction.
        step(1, 16'h0123, 1, 0, 3'b111);
        step(1, 16'h0123, 1, 0, 3'b111);
        check("rst_last", LastInstr, 16'h0000);
        check("rst_last2", Last2Instr, 16'h0000);
        check("rst_valid", {LastValid, Last2Valid}, 2'b00);
        check("rst_flag", Flag, 3'b000);
        check("rst_stall", Stall, 1'b0);

        // Load-use: LW R3 then ADD R4,R3,R2.
        step(0, 16'h8310, 1, 0, 3'b000);
        step(0, 16'h0432, 1, 0, 3'b000);
        check("lu_stall", obs_stall, 1'b1);
        check("lu_bubble", {LastInstr, 15'd0, LastValid}, 32'h0);
        step(0, 16'h0432, 1, 0, 3'b000);
        check("lu_stall_once", obs_stall, 1'b0);
        check("lu_ex", LastInstr, 16'h0432);
        check("lu_mem", Last2Instr, 16'h0000);

        // No false stalls: Rd=0 load, and LHB has no Rs read.
        step(0, 16'h8010, 1, 0, 3'b000);
        step(0, 16'h0400, 1, 0, 3'b000);
        check("r0_nostall", obs_stall, 1'b0);
        step(0, 16'h8310, 1, 0, 3'b000);
        step(0, 16'hA355, 1, 0, 3'b000);
        check("lhb_nostall", obs_stall, 1'b0);

        // JR depends on its Rd field.
        step(0, 16'h85A0, 1, 0, 3'b000);
        step(0, 16'hE500, 1, 0, 3'b000);
        check("jr_stall", obs_stall, 1'b1);
        step(0, 16'hE500, 1, 0, 3'b000);
        check("jr_stall_once", obs_stall, 1'b0);

        // Flush beats stall.
        step(0, 16'h8310, 1, 0, 3'b000);
        step(0, 16'h0432, 1, 1, 3'b000);
        check("fl_ex", LastInstr, 16'h0000);
        check("fl_valid", LastValid, 1'b0);
        check("fl_mem", Last2Instr, 16'h8310);
        step(0, 16'h0000, 0, 0, 3'b000);
        check("fl_squashed", Last2Instr, 16'h0000);

        // Flags: ADD sets all, AND sets only Z, bubble holds.
        step(0, 16'h0123, 1, 0, 3'b000);
        step(0, 16'h2123, 1, 0, 3'b101);
        check("flag_add", Flag, 3'b101);
        step(0, 16'h0000, 0, 0, 3'b010);
        check("flag_and", Flag, 3'b100);
        step(0, 16'h0000, 0, 0, 3'b111);
        check("flag_bubble", Flag, 3'b100);

        // Random traffic with hazard-rich registers; stalled instructions are re-presented.
        ri = 16'h0;
        for (int n = 0; n < 600; n++) begin
            if (!obs_stall) begin
                op = ($urandom_range(0, 3) == 0) ? 8 : int'($urandom_range(0, 15));
                ri = {op[3:0], 2'b00, 2'($urandom_range(0, 3)), 2'b00,
                      2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
            end
            rv = ($urandom_range(0, 9) != 0);
            rf = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 49) == 0);
            step(rr, ri, rv, rf, 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
